// File: rtl/cache_refill_controller.sv
// cache_refill_controller
// Miss handler that sits directly behind a direct-mapped cache.
//   - Hits in IDLE only bump the hit counter; this block never drives hit data.
//   - A miss stalls the CPU and latches the word-aligned address.
//   - The word is fetched from memory over a req/ready handshake, written into
//     the cache through a one-cycle fill strobe, then returned to the CPU.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid_i, req_addr_i       CPU access and its byte address
//   cache_hit_i                   cache hit flag for req_addr_i
//   stall_o                       combinational pipeline freeze
//   mem_req_o, mem_addr_o         memory read request and word address
//   mem_ready_i, mem_rdata_i      memory ready/data-valid and read data
//   fill_en_o, fill_set_o,
//   fill_tag_o, fill_data_o       one-cycle cache fill port
//   data_o, data_valid_o          refilled word returned to the CPU
//   hit_count_o, miss_count_o     saturating statistics counters
module cache_refill_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH  = 3,
    parameter int TAG_WIDTH  = 27,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  cache_hit_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_en_o,
    output logic [SET_WIDTH-1:0]  fill_set_o,
    output logic [TAG_WIDTH-1:0]  fill_tag_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);

    typedef enum logic [1:0] {IDLE, MEM_REQ, FILL, RESUME} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  mem_req_q, mem_req_d;
    logic                  fill_en_q, fill_en_d;
    logic                  data_valid_q, data_valid_d;
    logic [CNT_WIDTH-1:0]  hit_q, hit_d;
    logic [CNT_WIDTH-1:0]  miss_q, miss_d;
    logic                  miss_detect;

    assign miss_detect = (state_q == IDLE) && req_valid_i && !cache_hit_i;

    // The CPU is frozen from the miss-detect cycle until the word is handed
    // back; in RESUME the pipeline already runs so it can consume data_o.
    assign stall_o = miss_detect || (state_q == MEM_REQ) || (state_q == FILL);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        data_out_d   = data_out_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        mem_req_d    = 1'b0;
        fill_en_d    = 1'b0;
        data_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (cache_hit_i) begin
                        if (hit_q != {CNT_WIDTH{1'b1}}) hit_d = hit_q + CNT_WIDTH'(1);
                    end else begin
                        addr_d    = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        if (miss_q != {CNT_WIDTH{1'b1}}) miss_d = miss_q + CNT_WIDTH'(1);
                        mem_req_d = 1'b1;
                        state_d   = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                // Request stays up until ready is sampled; ready in the very
                // first request cycle is a legal zero-wait transfer.
                if (mem_ready_i) begin
                    rdata_d   = mem_rdata_i;
                    fill_en_d = 1'b1;
                    state_d   = FILL;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            FILL: begin
                data_out_d   = rdata_q;
                data_valid_d = 1'b1;
                state_d      = RESUME;
            end
            RESUME: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rdata_q      <= '0;
            data_out_q   <= '0;
            mem_req_q    <= 1'b0;
            fill_en_q    <= 1'b0;
            data_valid_q <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            data_out_q   <= data_out_d;
            mem_req_q    <= mem_req_d;
            fill_en_q    <= fill_en_d;
            data_valid_q <= data_valid_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q;
    assign fill_en_o    = fill_en_q;
    // Set/tag split must stay identical to the cache's own indexing.
    assign fill_set_o   = addr_q[SET_WIDTH+1:2];
    assign fill_tag_o   = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign fill_data_o  = rdata_q;
    assign data_o       = data_out_q;
    assign data_valid_o = data_valid_q;
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
module tb_cache_refill_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic        cache_hit_i;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    logic        stall_o, mem_req_o, fill_en_o, data_valid_o;
    logic [31:0] mem_addr_o, fill_data_o, data_o;
    logic [2:0]  fill_set_o;
    logic [26:0] fill_tag_o;
    logic [15:0] hit_count_o, miss_count_o;

    logic        s_stall, s_mem_req, s_fill_en, s_data_valid;
    logic [31:0] s_mem_addr, s_fill_data, s_data;
    logic [2:0]  s_fill_set;
    logic [26:0] s_fill_tag;
    logic [1:0]  s_hit_count, s_miss_count;

    int vectors = 0;
    int errors  = 0;
    int pulses;

    always #5 clk = ~clk;

    cache_refill_controller dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .cache_hit_i(cache_hit_i),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .fill_en_o(fill_en_o), .fill_set_o(fill_set_o), .fill_tag_o(fill_tag_o),
        .fill_data_o(fill_data_o), .data_o(data_o), .data_valid_o(data_valid_o),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    cache_refill_controller #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .cache_hit_i(cache_hit_i),
        .stall_o(s_stall), .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .fill_en_o(s_fill_en), .fill_set_o(s_fill_set), .fill_tag_o(s_fill_tag),
        .fill_data_o(s_fill_data), .data_o(s_data), .data_valid_o(s_data_valid),
        .hit_count_o(s_hit_count), .miss_count_o(s_miss_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req"},    64'(mem_req_o),    64'd0);
        check({tag, " mem_addr"},   64'(mem_addr_o),   64'd0);
        check({tag, " fill_en"},    64'(fill_en_o),    64'd0);
        check({tag, " fill_set"},   64'(fill_set_o),   64'd0);
        check({tag, " fill_tag"},   64'(fill_tag_o),   64'd0);
        check({tag, " fill_data"},  64'(fill_data_o),  64'd0);
        check({tag, " data"},       64'(data_o),       64'd0);
        check({tag, " data_valid"}, 64'(data_valid_o), 64'd0);
        check({tag, " hit_cnt"},    64'(hit_count_o),  64'd0);
        check({tag, " miss_cnt"},   64'(miss_count_o), 64'd0);
        check({tag, " stall"},      64'(stall_o),      64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; cache_hit_i = 1'b0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;

        // ---- 5 hits ----
        @(negedge clk);
        req_valid_i = 1'b1; cache_hit_i = 1'b1; req_addr_i = 32'h0000_0100;
        #1 check("hit stall", 64'(stall_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hit no mem_req", 64'(mem_req_o), 64'd0);
        end
        req_valid_i = 1'b0; cache_hit_i = 1'b0;
        check("hit_count", 64'(hit_count_o), 64'd5);
        check("hit miss_count", 64'(miss_count_o), 64'd0);
        check("sat hit_count", 64'(s_hit_count), 64'd3);

        // ---- zero-wait miss at 0x1234 ----
        @(negedge clk);
        req_valid_i = 1'b1; cache_hit_i = 1'b0; req_addr_i = 32'h0000_1234;
        mem_ready_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1 check("zw N stall", 64'(stall_o), 64'd1);
        @(negedge clk); // N+1
        req_valid_i = 1'b0;
        check("zw N+1 mem_req", 64'(mem_req_o), 64'd1);
        check("zw N+1 mem_addr", 64'(mem_addr_o), 64'h1234);
        check("zw N+1 miss_count", 64'(miss_count_o), 64'd1);
        @(negedge clk); // N+2
        check("zw N+2 fill_en", 64'(fill_en_o), 64'd1);
        check("zw N+2 fill_set", 64'(fill_set_o), 64'd5);
        check("zw N+2 fill_tag", 64'(fill_tag_o), 64'h91);
        check("zw N+2 fill_data", 64'(fill_data_o), 64'hDEAD_BEEF);
        check("zw N+2 mem_req", 64'(mem_req_o), 64'd0);
        check("zw N+2 stall", 64'(stall_o), 64'd1);
        @(negedge clk); // N+3
        check("zw N+3 data_valid", 64'(data_valid_o), 64'd1);
        check("zw N+3 data", 64'(data_o), 64'hDEAD_BEEF);
        check("zw N+3 stall", 64'(stall_o), 64'd0);
        check("zw N+3 fill_en", 64'(fill_en_o), 64'd0);
        mem_ready_i = 1'b0;
        @(negedge clk);
        check("zw after data_valid", 64'(data_valid_o), 64'd0);
        check("zw data held", 64'(data_o), 64'hDEAD_BEEF);

        // ---- reset mid-simulation ----
        rst_n = 1'b0;
        #1 check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- delayed miss: ready 3 cycles after request ----
        @(negedge clk);
        req_valid_i = 1'b1; cache_hit_i = 1'b0; req_addr_i = 32'h8000_00A7;
        mem_rdata_i = 32'h1234_5678;
        #1 check("dl N stall", 64'(stall_o), 64'd1);
        req_valid_i = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            check("dl mem_req", 64'(mem_req_o), 64'd1);
            check("dl mem_addr", 64'(mem_addr_o), 64'h8000_00A4);
            check("dl stall", 64'(stall_o), 64'd1);
            if (fill_en_o) pulses++;
            if (k == 4) mem_ready_i = 1'b1; else mem_ready_i = 1'b0;
        end
        @(negedge clk); // N+5
        mem_ready_i = 1'b0;
        check("dl fill_en", 64'(fill_en_o), 64'd1);
        check("dl fill_set", 64'(fill_set_o), 64'd1);
        check("dl fill_tag", 64'(fill_tag_o), 64'h400_0005);
        check("dl fill_data", 64'(fill_data_o), 64'h1234_5678);
        if (fill_en_o) pulses++;
        @(negedge clk); // N+6
        check("dl data_valid", 64'(data_valid_o), 64'd1);
        check("dl data", 64'(data_o), 64'h1234_5678);
        if (fill_en_o) pulses++;
        @(negedge clk); // N+7
        if (fill_en_o) pulses++;
        check("dl fill pulses", 64'(pulses), 64'd1);
        check("dl miss_count", 64'(miss_count_o), 64'd1);

        // ---- spurious ready in IDLE ----
        mem_ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("spur mem_req", 64'(mem_req_o), 64'd0);
            check("spur fill_en", 64'(fill_en_o), 64'd0);
            check("spur stall", 64'(stall_o), 64'd0);
        end
        mem_ready_i = 1'b0;

        // ---- reset during MEM_REQ, late ready ignored ----
        req_valid_i = 1'b1; cache_hit_i = 1'b0; req_addr_i = 32'h0000_0040;
        @(negedge clk);
        req_valid_i = 1'b0;
        check("rr mem_req before rst", 64'(mem_req_o), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rr async mem_req", 64'(mem_req_o), 64'd0);
        check("rr stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready_i = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (fill_en_o || data_valid_o || mem_req_o) pulses++;
        end
        mem_ready_i = 1'b0;
        check("rr late ready activity", 64'(pulses), 64'd0);
        check("rr miss_count", 64'(miss_count_o), 64'd0);

        // ---- 6 back-to-back zero-wait misses ----
        req_valid_i = 1'b1; cache_hit_i = 1'b0; req_addr_i = 32'h0000_2000;
        mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (data_valid_o) pulses++;
        end
        req_valid_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("sat data_valid pulses", 64'(pulses), 64'd6);
        check("main miss_count", 64'(miss_count_o), 64'd6);
        check("sat miss_count", 64'(s_miss_count), 64'd3);
        check("sat hit_count", 64'(s_hit_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
